// File: rtl/json_int_array_encoder.sv
// Streaming JSON encoder: signed integers in, compact "[a,b,c]" ASCII text out, one byte per beat.
// Define JSON_ENC_PRETTY_EN to emit a space after every ',' separator.
module json_int_array_encoder #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DIGITS = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_byte,
    output logic              out_last,
    output logic              frame_open
);

    localparam int unsigned BCD_W = DIGITS * 4;
    localparam int unsigned CNT_W = $clog2(DATA_W + 1);
    localparam int unsigned DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

`ifdef JSON_ENC_PRETTY_EN
    localparam bit PRETTY = 1'b1;
`else
    localparam bit PRETTY = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONV,
        S_LBRACK,
        S_SIGN,
        S_DIGIT,
        S_SEP,
        S_SPACE,
        S_RBRACK
    } state_e;

    state_e             state_q, state_d;
    logic [DATA_W-1:0]  mag_q, mag_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [BCD_W-1:0]   bcd_adj;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DIG_W-1:0]   dig_q, dig_d;
    logic [DIG_W-1:0]   msd;
    logic               neg_q, neg_d;
    logic               last_q, last_d;
    logic               out_valid_q, out_valid_d;
    logic [7:0]         out_byte_q, out_byte_d;
    logic               out_last_q, out_last_d;
    logic               frame_open_q, frame_open_d;
    logic               accept;
    logic               load;

    // ASCII character presented in a given emit state.
    function automatic logic [7:0] enc_byte(input state_e s, input logic [DIG_W-1:0] d,
                                            input logic [BCD_W-1:0] bcd);
        logic [7:0] b;
        case (s)
            S_LBRACK: b = 8'h5B;
            S_SIGN:   b = 8'h2D;
            S_DIGIT:  b = 8'h30 + {4'h0, bcd[4*d +: 4]};
            S_SEP:    b = 8'h2C;
            S_SPACE:  b = 8'h20;
            S_RBRACK: b = 8'h5D;
            default:  b = 8'h00;
        endcase
        return b;
    endfunction

    assign in_ready   = (state_q == S_IDLE);
    assign out_valid  = out_valid_q;
    assign out_byte   = out_byte_q;
    assign out_last   = out_last_q;
    assign frame_open = frame_open_q;

    // Next-state, conversion datapath and registered-output loading.
    always_comb begin
        state_d      = state_q;
        mag_d        = mag_q;
        bcd_d        = bcd_q;
        cnt_d        = cnt_q;
        dig_d        = dig_q;
        neg_d        = neg_q;
        last_d       = last_q;
        out_valid_d  = out_valid_q;
        out_byte_d   = out_byte_q;
        out_last_d   = out_last_q;
        frame_open_d = frame_open_q;
        load         = 1'b0;
        accept       = out_valid_q && out_ready;

        bcd_adj = bcd_q;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
        end

        // Most significant non-zero digit; zero value collapses to digit 0.
        msd = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (bcd_q[i*4 +: 4] != 4'd0) msd = DIG_W'(i);
        end

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    neg_d   = in_data[DATA_W-1];
                    mag_d   = in_data[DATA_W-1] ? (~in_data + DATA_W'(1)) : in_data;
                    last_d  = in_last;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = S_CONV;
                end
            end
            S_CONV: begin
                if (cnt_q != CNT_W'(DATA_W)) begin
                    {bcd_d, mag_d} = {bcd_adj, mag_q} << 1;
                    cnt_d          = cnt_q + CNT_W'(1);
                end else begin
                    dig_d   = msd;
                    load    = 1'b1;
                    state_d = !frame_open_q ? S_LBRACK : (neg_q ? S_SIGN : S_DIGIT);
                end
            end
            S_LBRACK: begin
                if (accept) begin
                    frame_open_d = 1'b1;
                    load         = 1'b1;
                    state_d      = neg_q ? S_SIGN : S_DIGIT;
                end
            end
            S_SIGN: begin
                if (accept) begin
                    load    = 1'b1;
                    state_d = S_DIGIT;
                end
            end
            S_DIGIT: begin
                if (accept) begin
                    load = 1'b1;
                    if (dig_q == '0) state_d = last_q ? S_RBRACK : S_SEP;
                    else             dig_d   = dig_q - DIG_W'(1);
                end
            end
            S_SEP: begin
                if (accept) begin
                    if (PRETTY) begin
                        load    = 1'b1;
                        state_d = S_SPACE;
                    end else begin
                        out_valid_d = 1'b0;
                        state_d     = S_IDLE;
                    end
                end
            end
            S_SPACE: begin
                if (accept) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            S_RBRACK: begin
                if (accept) begin
                    out_valid_d  = 1'b0;
                    out_last_d   = 1'b0;
                    frame_open_d = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (load) begin
            out_valid_d = 1'b1;
            out_byte_d  = enc_byte(state_d, dig_d, bcd_d);
            out_last_d  = (state_d == S_RBRACK);
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            mag_q        <= '0;
            bcd_q        <= '0;
            cnt_q        <= '0;
            dig_q        <= '0;
            neg_q        <= 1'b0;
            last_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            out_byte_q   <= 8'h00;
            out_last_q   <= 1'b0;
            frame_open_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mag_q        <= mag_d;
            bcd_q        <= bcd_d;
            cnt_q        <= cnt_d;
            dig_q        <= dig_d;
            neg_q        <= neg_d;
            last_q       <= last_d;
            out_valid_q  <= out_valid_d;
            out_byte_q   <= out_byte_d;
            out_last_q   <= out_last_d;
            frame_open_q <= frame_open_d;
        end
    end

endmodule

// File: tb/tb_json_int_array_encoder.sv
// Directed bench for json_int_array_encoder: table of frames plus latency and mid-frame reset sequences.
// Expected pretty-print text follows JSON_ENC_PRETTY_EN when defined.
module tb_json_int_array_encoder;

    localparam int DATA_W = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        in_last = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  out_byte;
    logic        out_last;
    logic        frame_open;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] got_q[$];
    bit         got_last_q[$];
    bit         got_fo_q[$];

    json_int_array_encoder #(.DATA_W(DATA_W), .DIGITS(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_byte   (out_byte),
        .out_last   (out_last),
        .frame_open (frame_open)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           n;
        logic [3:0][31:0] w;
        logic [3:0]   l;
        bit           rnd;
        logic [159:0] exp;
    } vec_t;

    vec_t vecs[7];

    function automatic vec_t mk(input int n, input logic [31:0] w0, input logic [31:0] w1,
                                input logic [31:0] w2, input logic [3:0] l, input bit rnd,
                                input logic [159:0] exp);
        vec_t v;
        v.n = n;
        v.w[0] = w0; v.w[1] = w1; v.w[2] = w2; v.w[3] = '0;
        v.l = l;
        v.rnd = rnd;
        v.exp = exp;
        return v;
    endfunction

    function automatic int exp_len(input logic [159:0] e);
        int len = 0;
        for (int i = 0; i < 20; i++) if (e[i*8 +: 8] != 8'h00) len++;
        return len;
    endfunction

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Present one element and wait (bounded) for it to be taken.
    task automatic send(input logic [31:0] d, input logic l);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        for (int c = 0; c < 300; c++) begin
            if (in_ready) begin
                @(posedge clk);
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        cmp("in_handshake", 64'(ok), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 'x;
        in_last  = 1'b0;
    endtask

    // Accept bytes until len collected or the cycle budget runs out.
    task automatic collect(input int len, input bit rnd);
        int c = 0;
        while (got_q.size() < len && c < 3000) begin
            @(negedge clk);
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid && out_ready) begin
                got_q.push_back(out_byte);
                got_last_q.push_back(out_last);
                got_fo_q.push_back(frame_open);
            end
            c++;
        end
    endtask

    task automatic check_frame(input string name, input logic [159:0] e);
        int len = exp_len(e);
        int m;
        logic [7:0] eb;
        cmp({name, "_len"}, 64'(got_q.size()), 64'(len));
        m = (got_q.size() < len) ? got_q.size() : len;
        for (int k = 0; k < m; k++) begin
            eb = e[(len-1-k)*8 +: 8];
            cmp({name, "_byte"}, 64'(got_q[k]), 64'(eb));
            cmp({name, "_last"}, 64'(got_last_q[k]), 64'(eb == 8'h5D));
            cmp({name, "_frame_open"}, 64'(got_fo_q[k]), 64'(eb != 8'h5B));
        end
        got_q.delete();
        got_last_q.delete();
        got_fo_q.delete();
    endtask

    task automatic idle_check(input string name);
        @(negedge clk);
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        cmp({name, "_idle"}, {61'd0, out_valid, frame_open, in_ready}, 64'b001);
    endtask

    task automatic run_vec(input vec_t v);
        fork
            begin
                for (int i = 0; i < v.n; i++) send(v.w[i], v.l[i]);
            end
            collect(exp_len(v.exp), v.rnd);
        join
        check_frame("vec", v.exp);
        idle_check("vec");
    endtask

    // Stalled byte must stay put until accepted.
    logic [7:0] hold_b;
    logic       hold_l;
    bit         hold_pend = 1'b0;
    always @(posedge clk) begin
        if (!rst_n) begin
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                cmp("hold_stable", {54'd0, out_valid, out_last, out_byte}, {54'd1, hold_l, hold_b});
            end
            hold_pend = out_valid && !out_ready;
            hold_b    = out_byte;
            hold_l    = out_last;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int lat;
        logic [159:0] pretty_exp;
`ifdef JSON_ENC_PRETTY_EN
        pretty_exp = "[1, -2]";
`else
        pretty_exp = "[1,-2]";
`endif
        vecs[0] = mk(1, 32'd0,         32'd0,   32'd0,  4'b0001, 1'b0, "[0]");
        vecs[1] = mk(3, 32'd12,        -32'sd5, 32'd0,  4'b0100, 1'b0, "[12,-5,0]");
        vecs[2] = mk(1, 32'd99,        32'd0,   32'd0,  4'b0001, 1'b1, "[99]");
        vecs[3] = mk(2, 32'd7,         -32'sd10, 32'd0, 4'b0011, 1'b0, "[7][-10]");
        vecs[4] = mk(2, 32'd1,         -32'sd2, 32'd0,  4'b0010, 1'b0, pretty_exp);
        vecs[5] = mk(1, 32'd2147483647, 32'd0,  32'd0,  4'b0001, 1'b1, "[2147483647]");
        vecs[6] = mk(3, 32'd100,       -32'sd1, 32'd10, 4'b0100, 1'b0, "[100,-1,10]");

        #2 rst_n = 1'b0;
        #1;
        cmp("reset_state", {52'd0, out_valid, out_byte, out_last, frame_open, in_ready},
            {52'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1});
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Latency and in_ready during conversion, with most-negative value.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 32'd1;
        in_last  = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 'x;
        cmp("conv_in_ready", 64'(in_ready), 64'd0);
        lat = 0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        cmp("first_byte_latency", 64'(lat), 64'(DATA_W + 1));
        fork
            send(32'h8000_0000, 1'b1);
            collect(15, 1'b0);
        join
        check_frame("min_int", "[1,-2147483648]");
        idle_check("min_int");

        // Reset with a frame open and a digit stalled on the output.
        fork
            send(32'd12, 1'b0);
            collect(4, 1'b0);
        join
        check_frame("pre_reset", "[12,");
        @(negedge clk);
        out_ready = 1'b0;
        send(32'd34, 1'b0);
        repeat (40) @(negedge clk);
        cmp("stalled_digit", {55'd0, out_valid, out_byte}, {55'd0, 1'b1, 8'h33});
        rst_n = 1'b0;
        #1;
        cmp("mid_reset", {52'd0, out_valid, out_byte, out_last, frame_open, in_ready},
            {52'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1});
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        run_vec(mk(1, 32'd5, 32'd0, 32'd0, 4'b0001, 1'b0, "[5]"));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
